// File: rtl/axi_lite_pair.sv
//------------------------------------------------------------------------------
// Module   : axi_lite_pair
// Purpose  : Loopback AXI4-Lite master/slave pair. A single-transaction master
//            writes TEST_DATA to TEST_ADDR on start_write and reads TEST_ADDR
//            back into rdata on start_read. The slave is a register buffer.
//            All five AXI channels are internal.
// Ports    : aclk        - clock, rising edge
//            areset_n    - asynchronous active-low reset
//            start_write - level, launches a write when the master is idle
//            start_read  - level, launches a read when idle (write has priority)
//            rdata       - data captured by the last read
//            resp        - BRESP/RRESP of the last completed transaction
//            busy        - master is not idle
//            wr_done     - one-cycle pulse after the B handshake
//            rd_done     - one-cycle pulse after the R handshake
// Options  : AXI_LITE_PAIR_SLVERR_EN - out-of-range addresses answer SLVERR,
//            writes are dropped and reads return 0. Undefined: upper address
//            bits alias and every response is OKAY.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axi_lite_pair #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 256,
   parameter logic [ADDR_WIDTH-1:0] TEST_ADDR  = 32'h0000_0004,
   parameter logic [DATA_WIDTH-1:0] TEST_DATA  = 32'hDEAD_BEEF
) (
   input  logic                  aclk,
   input  logic                  areset_n,
   input  logic                  start_write,
   input  logic                  start_read,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [1:0]            resp,
   output logic                  busy,
   output logic                  wr_done,
   output logic                  rd_done
);

   localparam int         IDX_W  = $clog2(DEPTH);
   localparam int         STRB_W = DATA_WIDTH / 8;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      WR_B = 3'd2,
      RD_A = 3'd3,
      RD_R = 3'd4
   } state_t;

   state_t state, state_nxt;

   // Internal AXI4-Lite channels
   logic                  awvalid, awready, wvalid, wready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_W-1:0]     wstrb;
   logic                  bvalid, bready;
   logic [1:0]            bresp;
   logic                  arvalid, arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  rvalid, rready;
   logic [DATA_WIDTH-1:0] rdata_bus;
   logic [1:0]            rresp;

   logic aw_hs, ar_hs, b_hs, r_hs;

   assign aw_hs = awvalid && awready;   // W always completes on the same edge
   assign b_hs  = bvalid && bready;
   assign ar_hs = arvalid && arready;
   assign r_hs  = rvalid && rready;

   //---------------------------------------------------------------- master
   assign awaddr = TEST_ADDR;
   assign araddr = TEST_ADDR;
   assign wdata  = TEST_DATA;
   assign wstrb  = '1;
   assign awprot = 3'b000;
   assign arprot = 3'b000;
   assign busy   = (state != IDLE);
   assign bready = (state == WR_B);
   assign rready = (state == RD_R);

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start_write)     state_nxt = WR;
            else if (start_read) state_nxt = RD_A;
         end
         WR:      if (aw_hs) state_nxt = WR_B;
         WR_B:    if (b_hs)  state_nxt = IDLE;
         RD_A:    if (ar_hs) state_nxt = RD_R;
         RD_R:    if (r_hs)  state_nxt = IDLE;
         default:            state_nxt = IDLE;
      endcase
   end

   // VALIDs are registered one cycle after entering the request state so they
   // never depend combinationally on READY; they drop on the handshake edge.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         arvalid <= 1'b0;
         wr_done <= 1'b0;
         rd_done <= 1'b0;
         rdata   <= '0;
         resp    <= OKAY;
      end else begin
         awvalid <= (state == WR) && !aw_hs;
         wvalid  <= (state == WR) && !aw_hs;
         arvalid <= (state == RD_A) && !ar_hs;
         wr_done <= b_hs;
         rd_done <= r_hs;
         if (b_hs) resp <= bresp;
         if (r_hs) begin
            resp  <= rresp;
            rdata <= rdata_bus;
         end
      end
   end

   //----------------------------------------------------------------- slave
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [IDX_W-1:0]      aw_idx, ar_idx;
   logic                  wr_err, rd_err;

   // Buffer index is the low address bits used directly (no byte shift)
   assign aw_idx = awaddr[IDX_W-1:0];
   assign ar_idx = araddr[IDX_W-1:0];

`ifdef AXI_LITE_PAIR_SLVERR_EN
   assign wr_err = |(awaddr >> IDX_W);
   assign rd_err = |(araddr >> IDX_W);
`else
   assign wr_err = 1'b0;
   assign rd_err = 1'b0;
`endif

   // Accepting AW and W only together keeps both on one edge
   assign awready = awvalid && wvalid && !bvalid;
   assign wready  = awvalid && wvalid && !bvalid;
   assign arready = arvalid && !rvalid;

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         bvalid    <= 1'b0;
         bresp     <= OKAY;
         rvalid    <= 1'b0;
         rresp     <= OKAY;
         rdata_bus <= '0;
      end else begin
         if (aw_hs && wready) begin
            if (!wr_err) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (wstrb[b]) mem[aw_idx][b*8 +: 8] <= wdata[b*8 +: 8];
               end
            end
            bvalid <= 1'b1;
            bresp  <= wr_err ? SLVERR : OKAY;
         end else if (b_hs) begin
            bvalid <= 1'b0;
         end

         if (ar_hs) begin
            rvalid    <= 1'b1;
            rresp     <= rd_err ? SLVERR : OKAY;
            rdata_bus <= rd_err ? '0 : mem[ar_idx];
         end else if (r_hs) begin
            rvalid <= 1'b0;
         end
      end
   end

   // Protection fields and upper address bits carry no meaning in this slave
   logic unused_bits;
   assign unused_bits = ^{awprot, arprot, awaddr, araddr};

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_pair.sv
//------------------------------------------------------------------------------
// Module   : tb_axi_lite_pair
// Purpose  : Self-checking bench for axi_lite_pair (default configuration).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_axi_lite_pair;

   logic        aclk = 1'b0;
   logic        areset_n = 1'b0;
   logic        start_write = 1'b0;
   logic        start_read = 1'b0;
   logic [31:0] rdata;
   logic [1:0]  resp;
   logic        busy, wr_done, rd_done;

   int tests = 0;
   int fails = 0;

   axi_lite_pair dut (
      .aclk        (aclk),
      .areset_n    (areset_n),
      .start_write (start_write),
      .start_read  (start_read),
      .rdata       (rdata),
      .resp        (resp),
      .busy        (busy),
      .wr_done     (wr_done),
      .rd_done     (rd_done)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic        sw;
      logic        sr;
      logic        exp_wr;
      logic        exp_rd;
      logic [31:0] exp_rdata;
      logic [31:0] exp_mem4;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drives the starts for one edge and returns the number of edges until a
   // done pulse is seen (0 if none within the bound) and which done fired.
   task automatic launch(input logic sw, input logic sr,
                         output int lat, output logic got_wr, output logic got_rd);
      @(negedge aclk);
      start_write = sw;
      start_read  = sr;
      @(posedge aclk);
      #1;
      start_write = 1'b0;
      start_read  = 1'b0;
      lat = 0; got_wr = 1'b0; got_rd = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge aclk);
         #1;
         if (wr_done || rd_done) begin
            lat = k; got_wr = wr_done; got_rd = rd_done;
            break;
         end
      end
   endtask

   initial begin
      int   lat;
      logic gw, gr;
      logic seen_rd;

      vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

      // Reset state
      repeat (10) @(posedge aclk);
      #1;
      areset_n = 1'b1;
      @(negedge aclk);
      check("rst_rdata", rdata, 32'h0);
      check("rst_resp", {30'b0, resp}, 32'h0);
      check("rst_flags", {29'b0, busy, wr_done, rd_done}, 32'h0);
      check("rst_mem4", dut.mem[4], 32'h0);

      // Table-driven transactions
      for (int i = 0; i < 5; i++) begin
         launch(vecs[i].sw, vecs[i].sr, lat, gw, gr);
         check($sformatf("v%0d_latency", i), lat, 3);
         check($sformatf("v%0d_wr_done", i), {31'b0, gw}, {31'b0, vecs[i].exp_wr});
         check($sformatf("v%0d_rd_done", i), {31'b0, gr}, {31'b0, vecs[i].exp_rd});
         check($sformatf("v%0d_busy", i), {31'b0, busy}, 32'h0);
         check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
         check($sformatf("v%0d_resp", i), {30'b0, resp}, 32'h0);
         check($sformatf("v%0d_mem4", i), dut.mem[4], vecs[i].exp_mem4);
         @(posedge aclk);
         #1;
         check($sformatf("v%0d_pulse_width", i), {30'b0, wr_done, rd_done}, 32'h0);
      end

      // Reset mid-write: valids drop immediately, buffer and rdata clear
      @(negedge aclk);
      start_write = 1'b1;
      @(posedge aclk);
      #1;
      start_write = 1'b0;
      @(posedge aclk);
      #1;
      check("mid_awvalid_before", {30'b0, dut.awvalid, dut.wvalid}, 32'h3);
      areset_n = 1'b0;
      #1;
      check("mid_valids", {29'b0, dut.awvalid, dut.wvalid, dut.arvalid}, 32'h0);
      check("mid_busy", {31'b0, busy}, 32'h0);
      check("mid_mem4", dut.mem[4], 32'h0);
      check("mid_rdata", rdata, 32'h0);
      @(negedge aclk);
      areset_n = 1'b1;

      // Busy ignore: a read pulse during the write must be dropped
      @(negedge aclk);
      start_write = 1'b1;
      @(posedge aclk);
      #1;
      start_write = 1'b0;
      @(negedge aclk);
      start_read = 1'b1;
      @(posedge aclk);
      #1;
      start_read = 1'b0;
      seen_rd = 1'b0;
      lat = 0;
      for (int k = 2; k <= 12; k++) begin
         @(posedge aclk);
         #1;
         if (rd_done) seen_rd = 1'b1;
         if (wr_done && lat == 0) lat = k;
      end
      check("busy_wr_latency", lat, 3);
      check("busy_no_read", {31'b0, seen_rd}, 32'h0);
      check("busy_rdata", rdata, 32'h0);
      check("busy_mem4", dut.mem[4], 32'hDEAD_BEEF);
      check("busy_idle", {31'b0, busy}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
